// File: rtl/reg_window_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// rwc_pkg : shared constants for the SPARC register-window controller.
//   - op_code encodings accepted on the operation handshake
//   - SPARC trap type (tt) values raised toward the trap unit
//   - FSM state encoding of the controller
//   - saturating 16-bit increment used by the optional trap counters
//     (enabled with `define RWC_TRAP_COUNT_EN)
// ---------------------------------------------------------------------------
package rwc_pkg;

   localparam logic [2:0] OP_NOP        = 3'd0;
   localparam logic [2:0] OP_SAVE       = 3'd1;
   localparam logic [2:0] OP_RESTORE    = 3'd2;
   localparam logic [2:0] OP_TRAP_ENTER = 3'd3;
   localparam logic [2:0] OP_RETT       = 3'd4;
   localparam logic [2:0] OP_WRWIM      = 3'd5;
   localparam logic [2:0] OP_WRCWP      = 3'd6;
   localparam logic [2:0] OP_RSVD       = 3'd7;

   localparam logic [7:0] TT_ILLEGAL = 8'h02;
   localparam logic [7:0] TT_WIN_OVF = 8'h05;
   localparam logic [7:0] TT_WIN_UNF = 8'h06;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EXEC = 2'd1;
   localparam logic [1:0] ST_TRAP = 2'd2;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/reg_window_ctrl_if.sv
// ---------------------------------------------------------------------------
// reg_window_ctrl_if : operation / trap handshake between the pipeline
// (master) and the register-window controller (slave).
//   op_valid/op_ready  request handshake, op_code + op_data operand
//   op_done            one-cycle completion pulse
//   trap_valid/type    trap request held until trap_ack
// ---------------------------------------------------------------------------
interface reg_window_ctrl_if;

   logic        op_valid;
   logic [2:0]  op_code;
   logic [31:0] op_data;
   logic        op_ready;
   logic        op_done;
   logic        trap_valid;
   logic [7:0]  trap_type;
   logic        trap_ack;

   modport master (
      output op_valid, op_code, op_data, trap_ack,
      input  op_ready, op_done, trap_valid, trap_type
   );

   modport slave (
      input  op_valid, op_code, op_data, trap_ack,
      output op_ready, op_done, trap_valid, trap_type
   );

endinterface

// File: rtl/reg_window_ctrl_map.sv
// ---------------------------------------------------------------------------
// reg_window_map : combinational architectural -> physical register index.
//   arch  in  5       architectural register number
//   cwp   in  5       current window pointer
//   phys  out PHYS_W  physical register-file index
// Globals map 1:1; outs/locals sit in the window's 16-entry slice; ins are
// the outs of window (cwp+1) mod NWINDOWS, giving the SPARC overlap.
// ---------------------------------------------------------------------------
module reg_window_map #(
   parameter int NWINDOWS = 8,
   parameter int PHYS_W   = 8
) (
   input  logic [4:0]        arch,
   input  logic [4:0]        cwp,
   output logic [PHYS_W-1:0] phys
);

   logic [4:0] cwp_in;

   always_comb begin
      cwp_in = (cwp == 5'(NWINDOWS - 1)) ? 5'd0 : cwp + 5'd1;
   end

   always_comb begin
      unique case (arch[4:3])
         2'b00:   phys = PHYS_W'(arch);
         2'b01:   phys = PHYS_W'(8)  + (PHYS_W'(cwp) << 4)    + PHYS_W'(arch[2:0]);
         2'b10:   phys = PHYS_W'(16) + (PHYS_W'(cwp) << 4)    + PHYS_W'(arch[2:0]);
         default: phys = PHYS_W'(8)  + (PHYS_W'(cwp_in) << 4) + PHYS_W'(arch[2:0]);
      endcase
   end

endmodule

// File: rtl/reg_window_ctrl.sv
// ---------------------------------------------------------------------------
// reg_window_ctrl : SPARC register-window controller.
//   Clk, Rst       clock, synchronous active-high reset
//   bus (slave)    op_valid/op_ready/op_code/op_data/op_done,
//                  trap_valid/trap_type/trap_ack
//   RA,RB,RD,RW    architectural register numbers
//   LE_in          architectural write enable
//   PRA..PRW       physical register-file indices (use registered cwp)
//   LE_out         physical write enable, never set for r0
//   cwp, wim       current window pointer, window invalid mask
//   ovf_count,     saturating window overflow/underflow trap counters,
//   unf_count      present only with `define RWC_TRAP_COUNT_EN
// FSM: IDLE accepts one op, EXEC applies it in one cycle, TRAP holds the
// trap request until acknowledged.
// ---------------------------------------------------------------------------
module reg_window_ctrl
   import rwc_pkg::*;
#(
   parameter int NWINDOWS = 8,
   parameter int PHYS_W   = 8
) (
   input  logic                Clk,
   input  logic                Rst,
   reg_window_ctrl_if.slave    bus,
   input  logic [4:0]          RA,
   input  logic [4:0]          RB,
   input  logic [4:0]          RD,
   input  logic [4:0]          RW,
   input  logic                LE_in,
   output logic [PHYS_W-1:0]   PRA,
   output logic [PHYS_W-1:0]   PRB,
   output logic [PHYS_W-1:0]   PRD,
   output logic [PHYS_W-1:0]   PRW,
   output logic                LE_out,
   output logic [4:0]          cwp,
   output logic [NWINDOWS-1:0] wim
`ifdef RWC_TRAP_COUNT_EN
   ,
   output logic [15:0]         ovf_count,
   output logic [15:0]         unf_count
`endif
);

   logic [1:0]          state_q, state_d;
   logic [2:0]          opc_q, opc_d;
   logic [31:0]         data_q, data_d;
   logic [4:0]          cwp_q, cwp_d;
   logic [NWINDOWS-1:0] wim_q, wim_d;
   logic                done_q, done_d;
   logic                trap_valid_q, trap_valid_d;
   logic [7:0]          trap_type_q, trap_type_d;

   // Neighbouring windows and their invalid bits
   logic [4:0] cwp_dn, cwp_up;
   logic       wim_dn_bit, wim_up_bit;

   always_comb begin
      cwp_dn     = (cwp_q == 5'd0) ? 5'(NWINDOWS - 1) : cwp_q - 5'd1;
      cwp_up     = (cwp_q == 5'(NWINDOWS - 1)) ? 5'd0 : cwp_q + 5'd1;
      wim_dn_bit = |(wim_q & (NWINDOWS'(1) << cwp_dn));
      wim_up_bit = |(wim_q & (NWINDOWS'(1) << cwp_up));
   end

   // NOTE: every output of this block gets a default first, so no path leaves
   // a variable unassigned and no latch is inferred.
   always_comb begin
      state_d      = state_q;
      opc_d        = opc_q;
      data_d       = data_q;
      cwp_d        = cwp_q;
      wim_d        = wim_q;
      done_d       = 1'b0;
      trap_valid_d = trap_valid_q;
      trap_type_d  = trap_type_q;

      case (state_q)
         ST_IDLE: begin
            if (bus.op_valid) begin
               state_d = ST_EXEC;
               opc_d   = bus.op_code;
               data_d  = bus.op_data;
            end
         end

         ST_EXEC: begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            case (opc_q)
               OP_SAVE: begin
                  if (wim_dn_bit) begin
                     state_d      = ST_TRAP;
                     done_d       = 1'b0;
                     trap_valid_d = 1'b1;
                     trap_type_d  = TT_WIN_OVF;
                  end else begin
                     cwp_d = cwp_dn;
                  end
               end
               // Trap entry always gets a window; overflow is the handler's job
               OP_TRAP_ENTER: cwp_d = cwp_dn;
               OP_RESTORE, OP_RETT: begin
                  if (wim_up_bit) begin
                     state_d      = ST_TRAP;
                     done_d       = 1'b0;
                     trap_valid_d = 1'b1;
                     trap_type_d  = TT_WIN_UNF;
                  end else begin
                     cwp_d = cwp_up;
                  end
               end
               OP_WRWIM: wim_d = data_q[NWINDOWS-1:0];
               OP_WRCWP: begin
                  if (data_q >= 32'(NWINDOWS)) begin
                     state_d      = ST_TRAP;
                     done_d       = 1'b0;
                     trap_valid_d = 1'b1;
                     trap_type_d  = TT_ILLEGAL;
                  end else begin
                     cwp_d = data_q[4:0];
                  end
               end
               OP_NOP, OP_RSVD: ;
               default: ;
            endcase
         end

         ST_TRAP: begin
            if (bus.trap_ack) begin
               trap_valid_d = 1'b0;
               state_d      = ST_IDLE;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values computed above, independent of block ordering.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q      <= ST_IDLE;
         opc_q        <= OP_NOP;
         data_q       <= '0;
         cwp_q        <= '0;
         wim_q        <= '0;
         done_q       <= 1'b0;
         trap_valid_q <= 1'b0;
         trap_type_q  <= '0;
      end else begin
         state_q      <= state_d;
         opc_q        <= opc_d;
         data_q       <= data_d;
         cwp_q        <= cwp_d;
         wim_q        <= wim_d;
         done_q       <= done_d;
         trap_valid_q <= trap_valid_d;
         trap_type_q  <= trap_type_d;
      end
   end

`ifdef RWC_TRAP_COUNT_EN
   logic [15:0] ovf_count_q, ovf_count_d;
   logic [15:0] unf_count_q, unf_count_d;
   logic        trap_entry;

   always_comb begin
      trap_entry  = trap_valid_d & ~trap_valid_q;
      ovf_count_d = ovf_count_q;
      unf_count_d = unf_count_q;
      if (trap_entry && trap_type_d == TT_WIN_OVF) ovf_count_d = sat_inc16(ovf_count_q);
      if (trap_entry && trap_type_d == TT_WIN_UNF) unf_count_d = sat_inc16(unf_count_q);
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         ovf_count_q <= '0;
         unf_count_q <= '0;
      end else begin
         ovf_count_q <= ovf_count_d;
         unf_count_q <= unf_count_d;
      end
   end

   assign ovf_count = ovf_count_q;
   assign unf_count = unf_count_q;
`else
`endif

   reg_window_map #(.NWINDOWS(NWINDOWS), .PHYS_W(PHYS_W)) u_map_a (.arch(RA), .cwp(cwp_q), .phys(PRA));
   reg_window_map #(.NWINDOWS(NWINDOWS), .PHYS_W(PHYS_W)) u_map_b (.arch(RB), .cwp(cwp_q), .phys(PRB));
   reg_window_map #(.NWINDOWS(NWINDOWS), .PHYS_W(PHYS_W)) u_map_d (.arch(RD), .cwp(cwp_q), .phys(PRD));
   reg_window_map #(.NWINDOWS(NWINDOWS), .PHYS_W(PHYS_W)) u_map_w (.arch(RW), .cwp(cwp_q), .phys(PRW));

   assign LE_out         = LE_in & (RW != 5'd0);
   assign bus.op_ready   = (state_q == ST_IDLE);
   assign bus.op_done    = done_q;
   assign bus.trap_valid = trap_valid_q;
   assign bus.trap_type  = trap_type_q;
   assign cwp            = cwp_q;
   assign wim            = wim_q;

endmodule

// File: tb/tb_reg_window_ctrl.sv
// ---------------------------------------------------------------------------
// tb_reg_window_ctrl : directed scoreboard bench for reg_window_ctrl.
// Stimulus pushes the expected completion/trap into a queue when an op is
// issued; a monitor pops and compares whenever op_done or a new trap appears.
// ---------------------------------------------------------------------------
module tb_reg_window_ctrl;
   import rwc_pkg::*;

   localparam int NW = 8;
   localparam int PW = 8;

   typedef struct {
      bit          is_trap;
      logic [7:0]  tt;
      logic [4:0]  cwp;
      logic [NW-1:0] wim;
   } exp_t;

   logic          Clk = 1'b0;
   logic          Rst = 1'b1;
   logic [4:0]    ra = '0, rb = '0, rd = '0, rw = '0;
   logic          le_in = 1'b0;
   logic [PW-1:0] pra, prb, prd, prw;
   logic          le_out;
   logic [4:0]    cwp;
   logic [NW-1:0] wim;
`ifdef RWC_TRAP_COUNT_EN
   logic [15:0]   ovf_count, unf_count;
`endif

   reg_window_ctrl_if bus();

   reg_window_ctrl #(.NWINDOWS(NW), .PHYS_W(PW)) dut (
      .Clk(Clk), .Rst(Rst), .bus(bus),
      .RA(ra), .RB(rb), .RD(rd), .RW(rw), .LE_in(le_in),
      .PRA(pra), .PRB(prb), .PRD(prd), .PRW(prw), .LE_out(le_out),
      .cwp(cwp), .wim(wim)
`ifdef RWC_TRAP_COUNT_EN
      , .ovf_count(ovf_count), .unf_count(unf_count)
`endif
   );

   always #5 Clk = ~Clk;

   int   n_checks = 0;
   int   n_pass   = 0;
   exp_t exp_q[$];
   bit   trap_seen = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act === expv) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic push_done(input logic [4:0] c, input logic [NW-1:0] w);
      exp_t e;
      e.is_trap = 0; e.tt = '0; e.cwp = c; e.wim = w;
      exp_q.push_back(e);
   endtask

   task automatic push_trap(input logic [7:0] tt, input logic [4:0] c, input logic [NW-1:0] w);
      exp_t e;
      e.is_trap = 1; e.tt = tt; e.cwp = c; e.wim = w;
      exp_q.push_back(e);
   endtask

   // Present an op once the controller is ready; returns just after accept edge
   task automatic issue(input logic [2:0] code, input logic [31:0] data);
      for (int i = 0; i < 20 && !bus.op_ready; i++) tick();
      if (!bus.op_ready) check("ready_timeout", 32'(bus.op_ready), 32'd1);
      bus.op_valid = 1'b1;
      bus.op_code  = code;
      bus.op_data  = data;
      tick();
      bus.op_valid = 1'b0;
   endtask

   // Wait (bounded) until a completion or trap is visible; ends at a negedge
   task automatic wait_resp();
      bit seen = 0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge Clk);
         seen = bus.op_done | bus.trap_valid;
      end
      if (!seen) check("resp_timeout", 32'd0, 32'd1);
   endtask

   task automatic ack_trap();
      repeat (2) begin
         @(negedge Clk);
         check("trap_held", 32'(bus.trap_valid), 32'd1);
         check("ready_in_trap", 32'(bus.op_ready), 32'd0);
      end
      bus.trap_ack = 1'b1;
      @(posedge Clk);
      #1 bus.trap_ack = 1'b0;
      @(negedge Clk);
      check("trap_cleared", 32'(bus.trap_valid), 32'd0);
      check("ready_after_ack", 32'(bus.op_ready), 32'd1);
   endtask

   // Scoreboard monitor
   initial begin
      exp_t e;
      forever begin
         @(negedge Clk);
         if (Rst) begin
            trap_seen = 0;
         end else begin
            if (bus.op_done) begin
               if (exp_q.size() == 0) check("unexpected_done", 32'd1, 32'd0);
               else begin
                  e = exp_q.pop_front();
                  check("event_is_trap", 32'd0, 32'(e.is_trap));
                  check("done_cwp", 32'(cwp), 32'(e.cwp));
                  check("done_wim", 32'(wim), 32'(e.wim));
               end
            end
            if (bus.trap_valid && !trap_seen) begin
               trap_seen = 1;
               if (exp_q.size() == 0) check("unexpected_trap", 32'd1, 32'd0);
               else begin
                  e = exp_q.pop_front();
                  check("event_is_trap", 32'd1, 32'(e.is_trap));
                  check("trap_type", 32'(bus.trap_type), 32'(e.tt));
                  check("trap_cwp", 32'(cwp), 32'(e.cwp));
                  check("trap_wim", 32'(wim), 32'(e.wim));
               end
            end
            if (!bus.trap_valid) trap_seen = 0;
         end
      end
   end

   initial begin
      bus.op_valid = 1'b0;
      bus.op_code  = OP_NOP;
      bus.op_data  = '0;
      bus.trap_ack = 1'b0;

      // Reset
      repeat (2) tick();
      Rst = 1'b0;
      @(negedge Clk);
      check("rst_cwp", 32'(cwp), 32'd0);
      check("rst_wim", 32'(wim), 32'd0);
      check("rst_ready", 32'(bus.op_ready), 32'd1);
      check("rst_done", 32'(bus.op_done), 32'd0);
      check("rst_trap_valid", 32'(bus.trap_valid), 32'd0);
      check("rst_trap_type", 32'(bus.trap_type), 32'd0);

      // Mapping at cwp=0
      ra = 5'd9; rb = 5'd17; rd = 5'd25; rw = 5'd0; le_in = 1'b1;
      #1;
      check("map0_out", 32'(pra), 32'd9);
      check("map0_local", 32'(prb), 32'd17);
      check("map0_in", 32'(prd), 32'd25);
      check("le_r0", 32'(le_out), 32'd0);
      rw = 5'd5;
      #1;
      check("le_r5", 32'(le_out), 32'd1);
      check("map0_global", 32'(prw), 32'd5);

      // SAVE from cwp=0: EXEC still translates with the old window
      push_done(5'd7, 8'h00);
      issue(OP_SAVE, 32'd0);
      @(negedge Clk);
      check("exec_no_done", 32'(bus.op_done), 32'd0);
      check("exec_old_cwp", 32'(cwp), 32'd0);
      check("exec_old_map", 32'(prd), 32'd25);
      check("exec_not_ready", 32'(bus.op_ready), 32'd0);
      wait_resp();
      check("save_done_pulse", 32'(bus.op_done), 32'd1);
      ra = 5'd25; rb = 5'd8;
      #1;
      check("map7_in_alias", 32'(pra), 32'd9);
      check("map7_out", 32'(prb), 32'd120);

      // Overflow: wim=0x40, SAVE from 7 -> window 6 invalid
      push_done(5'd7, 8'h40);
      issue(OP_WRWIM, 32'h40);
      wait_resp();
      push_trap(TT_WIN_OVF, 5'd7, 8'h40);
      issue(OP_SAVE, 32'd0);
      wait_resp();
      ack_trap();
      check("ovf_no_cwp_change", 32'(cwp), 32'd7);

      // Underflow: wim=0x01, RESTORE from 7 wraps to 0
      push_done(5'd7, 8'h01);
      issue(OP_WRWIM, 32'h01);
      wait_resp();
      push_trap(TT_WIN_UNF, 5'd7, 8'h01);
      issue(OP_RESTORE, 32'd0);
      wait_resp();
      ack_trap();

      // TRAP_ENTER ignores WIM
      push_done(5'd0, 8'h01);
      issue(OP_WRCWP, 32'd0);
      wait_resp();
      push_done(5'd0, 8'h80);
      issue(OP_WRWIM, 32'h80);
      wait_resp();
      push_done(5'd7, 8'h80);
      issue(OP_TRAP_ENTER, 32'd0);
      wait_resp();

`ifdef RWC_TRAP_COUNT_EN
      check("ovf_count", 32'(ovf_count), 32'd1);
      check("unf_count", 32'(unf_count), 32'd1);
`endif

      // Illegal CWP write, then a legal one
      push_trap(TT_ILLEGAL, 5'd7, 8'h80);
      issue(OP_WRCWP, 32'd8);
      wait_resp();
      ack_trap();
      push_done(5'd3, 8'h80);
      issue(OP_WRCWP, 32'd3);
      wait_resp();
      ra = 5'd31; rb = 5'd16; rd = 5'd15;
      #1;
      check("map3_in", 32'(pra), 32'd79);
      check("map3_local", 32'(prb), 32'd64);
      check("map3_out", 32'(prd), 32'd63);

      // RETT and NOP; trap_ack while idle is ignored
      push_done(5'd4, 8'h80);
      issue(OP_RETT, 32'd0);
      wait_resp();
      push_done(5'd4, 8'h80);
      issue(OP_NOP, 32'd0);
      wait_resp();
      tick();
      bus.trap_ack = 1'b1;
      tick();
      bus.trap_ack = 1'b0;
      @(negedge Clk);
      check("idle_ack_ready", 32'(bus.op_ready), 32'd1);
      check("idle_ack_cwp", 32'(cwp), 32'd4);

      // Reset while in TRAP
      push_done(5'd4, 8'h08);
      issue(OP_WRWIM, 32'h08);
      wait_resp();
      push_trap(TT_WIN_OVF, 5'd4, 8'h08);
      issue(OP_SAVE, 32'd0);
      wait_resp();
      #1 Rst = 1'b1;
      tick();
      Rst = 1'b0;
      @(negedge Clk);
      check("rst_trap_cwp", 32'(cwp), 32'd0);
      check("rst_trap_wim", 32'(wim), 32'd0);
      check("rst_trap_valid_clr", 32'(bus.trap_valid), 32'd0);
      check("rst_trap_ready", 32'(bus.op_ready), 32'd1);

      // Reset during EXEC of a SAVE: no completion, no window change
      push_done(5'd3, 8'h00);
      issue(OP_WRCWP, 32'd3);
      wait_resp();
      tick();
      bus.op_valid = 1'b1;
      bus.op_code  = OP_SAVE;
      tick();
      bus.op_valid = 1'b0;
      Rst = 1'b1;
      tick();
      Rst = 1'b0;
      @(negedge Clk);
      check("rst_exec_cwp", 32'(cwp), 32'd0);
      check("rst_exec_wim", 32'(wim), 32'd0);
      check("rst_exec_done", 32'(bus.op_done), 32'd0);
      check("rst_exec_ready", 32'(bus.op_ready), 32'd1);
      repeat (3) @(negedge Clk);

      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule

// File: doc/reg_window_ctrl.md
Name: reg_window_ctrl

Overview:
SPARC register-window controller sitting in front of the 3-read/1-write register file.
- Owns CWP (current window pointer) and WIM (window invalid mask).
- Translates 5-bit architectural register numbers (RA, RB, RD, RW) into physical register-file indices.
- Sequences SAVE, RESTORE, trap-entry, RETT and WIM/CWP writes through a valid/ready handshake.
- Raises window overflow/underflow and illegal-CWP traps toward the trap unit.

Parameters:
NWINDOWS, 8, number of register windows (2..32); physical register count = 8 + 16*NWINDOWS.
PHYS_W, 8, physical index width; must satisfy 2**PHYS_W >= 8 + 16*NWINDOWS.

Ports:
Clk  in  1  clock; all state updates on rising edge.
Rst  in  1  synchronous, active-high reset.
op_valid  in  1  operation request.
op_code  in  3  0 NOP, 1 SAVE, 2 RESTORE, 3 TRAP_ENTER, 4 RETT, 5 WRWIM, 6 WRCWP, 7 reserved.
op_data  in  32  operand for WRWIM (low NWINDOWS bits) and WRCWP (full value).
op_ready  out  1  high only in IDLE.
op_done  out  1  one-cycle pulse on successful completion.
trap_valid  out  1  trap request; held until acknowledged.
trap_type  out  8  SPARC tt: 0x05 window_overflow, 0x06 window_underflow, 0x02 illegal_instruction.
trap_ack  in  1  trap unit acknowledge.
RA, RB, RD, RW  in  5 each  architectural register numbers.
LE_in  in  1  architectural write enable.
PRA, PRB, PRD, PRW  out  PHYS_W each  physical indices to the register file.
LE_out  out  1  physical write enable = LE_in & (RW != 0).
cwp  out  5  current window pointer.
wim  out  NWINDOWS  window invalid mask.

Behaviour:
- Reset (Rst=1 at edge): state IDLE; cwp=0; wim=0; op_done=0; trap_valid=0; trap_type=0. Reset mid-EXEC or mid-TRAP aborts the operation with no CWP/WIM update.
- Mapping (combinational, uses the registered cwp), for r the 5-bit architectural number:
  - r 0..7 (globals): phys = r.
  - r 8..15 (outs): phys = 8 + 16*cwp + (r-8).
  - r 16..23 (locals): phys = 16 + 16*cwp + (r-16).
  - r 24..31 (ins): phys = 8 + 16*((cwp+1) mod NWINDOWS) + (r-24). Window w ins therefore alias window w+1 outs.
- r0 writes: physical r0 is never written; LE_out is forced 0 when RW=0.
- FSM states: IDLE, EXEC, TRAP.
- IDLE: op_ready=1. op_valid & op_ready at edge k → EXEC; opcode and op_data are latched.
- EXEC (one cycle), at edge k+1:
  - SAVE and TRAP_ENTER compute new = (cwp-1) mod NWINDOWS; RESTORE and RETT compute new = (cwp+1) mod NWINDOWS. Wrap-around: 0-1 → NWINDOWS-1.
  - SAVE with wim[new]=1 → TRAP, tt 0x05, cwp unchanged.
  - RESTORE or RETT with wim[new]=1 → TRAP, tt 0x06, cwp unchanged.
  - TRAP_ENTER never checks WIM.
  - WRWIM: wim <= op_data[NWINDOWS-1:0].
  - WRCWP: if op_data >= NWINDOWS → TRAP, tt 0x02; else cwp <= op_data.
  - NOP and reserved opcodes: no state change.
  - Success: cwp/wim updated at edge k+1; op_done=1 during cycle k+1→k+2; return to IDLE. Next accept is possible at edge k+2 (throughput one op per 2 cycles).
- TRAP: trap_valid=1 and trap_type stable until trap_ack is sampled high. Then trap_valid=0 at that edge and state returns to IDLE. op_done is not pulsed for trapping ops.
- Mapping outputs switch to the new cwp in the same cycle op_done is high. Translations during EXEC use the old cwp.
- trap_ack outside TRAP is ignored. op_valid outside IDLE is not accepted.

Optional Feature:
RWC_TRAP_COUNT_EN
- Defined: adds outputs ovf_count[15:0] and unf_count[15:0], saturating at 0xFFFF. Each increments on entry to TRAP with tt 0x05 or 0x06 respectively. Both reset to 0.
- Undefined: ports and counters are absent. All other behaviour is identical.

Decomposition:
- Package rwc_pkg: op_code constants (OP_NOP..OP_WRCWP), trap type constants (TT_WIN_OVF=0x05, TT_WIN_UNF=0x06, TT_ILLEGAL=0x02), FSM state encoding.
- Sub-module reg_window_map: purely combinational (arch 5-bit, cwp) → phys PHYS_W, parameterised by NWINDOWS. Instantiated four times (A, B, D, W).

Test Plan:
- Reset, cwp=0: RA=9 → PRA=9; RA=17 → PRA=17; RA=25 → PRA=25 (8+16*1+1); RW=0 with LE_in=1 → LE_out=0.
- SAVE from cwp=0, wim=0: op accepted → cwp=7 with op_done one cycle after EXEC. Then RA=25 → PRA=9 (window 0 outs), RA=8 → PRA=120.
- WRWIM op_data=0x40, cwp=7, then SAVE → trap_valid=1, trap_type=0x05, cwp stays 7, op_ready=0. trap_ack high for one cycle → trap_valid=0, IDLE.
- WRWIM 0x01, cwp=7, RESTORE → wraps to window 0, which is invalid → tt 0x06. TRAP_ENTER from cwp=0 with wim=0x80 → cwp=7, no trap.
- WRCWP op_data=8 → tt 0x02, cwp unchanged. WRCWP op_data=3 → cwp=3, RA=31 → PRA=8+16*4+7=79.
- Assert Rst during TRAP and during EXEC of a SAVE → cwp=0, wim=0, trap_valid=0, op_ready=1 next cycle.
